id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register.
- Directly consumes the decoded control bundle (reg_dest, jump, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop) together with the ID-stage operands.
- Holds them for the EX stage and contains the load-use hazard detector, which inserts bubbles and stalls the front end.
- Supports a downstream hold and a branch/jump flush, and keeps a saturating count of inserted bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register
// with load-use bubble insertion and bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_reg_dest,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic [1:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_reg_dest,
  output logic              ex_jump,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              stall_front,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic       valid;
    logic       reg_dest;
    logic       jump;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_BUBBLE
  } act_t;

  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] pc4_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              id_uses_rt;
  logic              rt_live;
  logic              load_use;
  logic              bubble_req;
  act_t              act;

  // Incoming control bundle; a non-valid ID slot contributes no controls.
  always_comb begin
    id_ctrl          = '0;
    id_ctrl.valid    = id_valid;
    id_ctrl.reg_dest = id_valid & id_reg_dest;
    id_ctrl.jump     = id_valid & id_jump;
    id_ctrl.branch   = id_valid & id_branch;
    id_ctrl.memread  = id_valid & id_memread;
    id_ctrl.memtoreg = id_valid & id_memtoreg;
    id_ctrl.memwrite = id_valid & id_memwrite;
    id_ctrl.alusrc   = id_valid & id_alusrc;
    id_ctrl.regwrite = id_valid & id_regwrite;
    id_ctrl.aluop    = id_valid ? id_aluop : 2'b00;
  end

  // Load-use detection against the load sitting in EX; $0 never hazards.
  always_comb begin
    id_uses_rt = id_reg_dest | id_branch | id_memwrite;
    rt_live    = ex_ctrl.valid
               & ex_ctrl.memread
               & (rt_q != '0);
    load_use   = rt_live
               & id_valid
               & ((rt_q == id_rs)
                 | (id_uses_rt & (rt_q == id_rt)));
    bubble_req = flush | load_use;
  end

  assign stall_front = load_use | ex_hold;

  // Select one action per edge: hold beats flush/bubble beats load.
  always_comb begin
    act = ACT_LOAD;
    unique case (1'b1)
      ex_hold:               act = ACT_HOLD;
      !ex_hold & bubble_req: act = ACT_BUBBLE;
      default:               act = ACT_LOAD;
    endcase
  end

  // EX register: hold, insert a zeroed bubble, or capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
    end else begin
      unique case (act)
        ACT_HOLD: begin
          ex_ctrl <= ex_ctrl;
        end
        ACT_BUBBLE: begin
          ex_ctrl  <= '0;
          rs_q     <= '0;
          rt_q     <= '0;
          rd_q     <= '0;
          rdata1_q <= '0;
          rdata2_q <= '0;
          imm_q    <= '0;
          pc4_q    <= '0;
        end
        default: begin
          ex_ctrl  <= id_ctrl;
          rs_q     <= id_rs;
          rt_q     <= id_rt;
          rd_q     <= id_rd;
          rdata1_q <= id_rdata1;
          rdata2_q <= id_rdata2;
          imm_q    <= id_imm;
          pc4_q    <= id_pc4;
        end
      endcase
    end
  end

  // Saturating count of bubbles actually loaded into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (act == ACT_BUBBLE && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid    = ex_ctrl.valid;
  assign ex_reg_dest = ex_ctrl.reg_dest;
  assign ex_jump     = ex_ctrl.jump;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_pc4      = pc4_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register,
// hazard detector, flush/hold priority and bubble counter.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_reg_dest, id_jump, id_branch, id_memread;
  logic        id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0]  id_aluop;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic        ex_hold, flush;

  logic        ex_valid, ex_reg_dest, ex_jump, ex_branch, ex_memread;
  logic        ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic        stall_front;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_reg_dest, s_jump, s_branch, s_memread;
  logic        s_memtoreg, s_memwrite, s_alusrc, s_regwrite;
  logic [1:0]  s_aluop;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
  logic        s_stall;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_reg_dest(id_reg_dest), .id_jump(id_jump),
    .id_branch(id_branch), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_hold(ex_hold), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_dest(ex_reg_dest),
    .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .stall_front(stall_front), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(4)) sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_reg_dest(id_reg_dest), .id_jump(id_jump),
    .id_branch(id_branch), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_hold(ex_hold), .flush(flush),
    .ex_valid(s_valid), .ex_reg_dest(s_reg_dest),
    .ex_jump(s_jump), .ex_branch(s_branch),
    .ex_memread(s_memread), .ex_memtoreg(s_memtoreg),
    .ex_memwrite(s_memwrite), .ex_alusrc(s_alusrc),
    .ex_regwrite(s_regwrite), .ex_aluop(s_aluop),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2),
    .ex_imm(s_imm), .ex_pc4(s_pc4),
    .stall_front(s_stall), .bubble_cnt(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_reg_dest = 0; id_jump = 0;
    id_branch = 0; id_memread = 0; id_memtoreg = 0;
    id_memwrite = 0; id_alusrc = 0; id_regwrite = 0;
    id_aluop = 2'b00; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_pc4 = 0;
  endtask

  task automatic drv_add(input logic [4:0] rs,
                         input logic [4:0] rt,
                         input logic [4:0] rd,
                         input logic [31:0] d1,
                         input logic [31:0] d2);
    idle();
    id_valid = 1; id_reg_dest = 1; id_regwrite = 1;
    id_aluop = 2'b10; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_pc4 = 32'h104;
  endtask

  task automatic drv_lw(input logic [4:0] rs,
                        input logic [4:0] rt);
    idle();
    id_valid = 1; id_memread = 1; id_memtoreg = 1;
    id_alusrc = 1; id_regwrite = 1;
    id_rs = rs; id_rt = rt; id_imm = 32'h4;
  endtask

  task automatic drv_addi(input logic [4:0] rs,
                          input logic [4:0] rt);
    idle();
    id_valid = 1; id_alusrc = 1; id_regwrite = 1;
    id_rs = rs; id_rt = rt; id_imm = 32'h8;
  endtask

  task automatic drv_sw(input logic [4:0] rs,
                        input logic [4:0] rt);
    idle();
    id_valid = 1; id_memwrite = 1; id_alusrc = 1;
    id_rs = rs; id_rt = rt; id_imm = 32'hc;
  endtask

  initial begin
    rst_n = 0; ex_hold = 0; flush = 0;
    idle();
    #3;
    chk("rst_valid", ex_valid, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_stall", stall_front, 0);
    step();
    rst_n = 1;

    // plain R-type add
    drv_add(5'd1, 5'd2, 5'd3, 32'h10, 32'h20);
    #1;
    chk("add_stall", stall_front, 0);
    step();
    chk("add_valid", ex_valid, 1);
    chk("add_regwrite", ex_regwrite, 1);
    chk("add_aluop", ex_aluop, 2'b10);
    chk("add_rs", ex_rs, 1);
    chk("add_rt", ex_rt, 2);
    chk("add_rd", ex_rd, 3);
    chk("add_rdata1", ex_rdata1, 32'h10);
    chk("add_rdata2", ex_rdata2, 32'h20);
    chk("add_pc4", ex_pc4, 32'h104);

    // load-use: lw rt=5 then add rs=5
    drv_lw(5'd1, 5'd5);
    #1;
    chk("lw_nostall", stall_front, 0);
    step();
    chk("lw_memread", ex_memread, 1);
    drv_add(5'd5, 5'd6, 5'd7, 32'h55, 32'h66);
    #1;
    chk("lu_stall", stall_front, 1);
    step();
    chk("lu_valid", ex_valid, 0);
    chk("lu_regwrite", ex_regwrite, 0);
    chk("lu_memread", ex_memread, 0);
    chk("lu_cnt", bubble_cnt, 1);
    chk("lu_stall_gone", stall_front, 0);
    step();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rs", ex_rs, 5);
    chk("lu_add_rd", ex_rd, 7);

    // no hazard through $0
    drv_lw(5'd2, 5'd0);
    step();
    drv_add(5'd0, 5'd0, 5'd4, 32'h0, 32'h0);
    #1;
    chk("r0_stall", stall_front, 0);
    // lw rt=7, then addi/sw consumers
    drv_lw(5'd1, 5'd7);
    #1;
    chk("lw7_nostall", stall_front, 0);
    step();
    drv_addi(5'd1, 5'd7);
    #1;
    chk("addi_stall", stall_front, 0);
    drv_sw(5'd1, 5'd7);
    #1;
    chk("sw_stall", stall_front, 1);
    step();
    chk("sw_bubble_valid", ex_valid, 0);
    chk("sw_cnt", bubble_cnt, 2);
    step();
    chk("sw_memwrite", ex_memwrite, 1);
    chk("sw_rt", ex_rt, 7);

    // flush loads a bubble
    drv_add(5'd1, 5'd2, 5'd3, 32'h10, 32'h20);
    flush = 1;
    step();
    chk("fl_valid", ex_valid, 0);
    chk("fl_rdata1", ex_rdata1, 0);
    chk("fl_cnt", bubble_cnt, 3);
    flush = 0;
    step();
    chk("fl_reload", ex_valid, 1);

    // hold beats flush
    flush = 1; ex_hold = 1;
    #1;
    chk("hf_stall", stall_front, 1);
    step();
    chk("hf_valid", ex_valid, 1);
    chk("hf_rd", ex_rd, 3);
    chk("hf_cnt", bubble_cnt, 3);
    flush = 0;

    // hold for three cycles with new ID data
    drv_add(5'd8, 5'd9, 5'd9, 32'hdead, 32'hbeef);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rd", ex_rd, 3);
      chk("hold_rdata1", ex_rdata1, 32'h10);
      chk("hold_stall", stall_front, 1);
    end
    ex_hold = 0;

    // non-valid ID: controls dropped, fields captured
    id_valid = 0;
    step();
    chk("nv_valid", ex_valid, 0);
    chk("nv_regwrite", ex_regwrite, 0);
    chk("nv_aluop", ex_aluop, 0);
    chk("nv_rd", ex_rd, 9);
    id_valid = 1;
    step();
    chk("pre_rst_valid", ex_valid, 1);

    // asynchronous reset between edges
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_regwrite", ex_regwrite, 0);
    chk("arst_rdata1", ex_rdata1, 0);
    chk("arst_cnt", bubble_cnt, 0);
    chk("arst_scnt", s_cnt, 0);
    step();
    rst_n = 1;

    // saturation: 19 flushes
    flush = 1;
    for (int i = 0; i < 19; i++) step();
    chk("sat_cnt4", s_cnt, 4'hf);
    chk("sat_cnt16", bubble_cnt, 19);
    flush = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
